// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback sources.
// Latency: grant is combinational; the write appears on rf_write_* one cycle after the handshake.
// Backpressure: one requester (at most) sees req_ready per cycle; flush or reset withholds all grants.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rf_write_enable,
  output logic [ADDR_W-1:0]           rf_write_addr,
  output logic [DATA_W-1:0]           rf_write_data,
  output logic                        pend_valid,
  output logic [ADDR_W-1:0]           pend_addr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  // Requester index after p, wrapping at NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Round-robin pointer: the index searched first in the current cycle.
  logic [PTR_W-1:0]  r_rr_ptr;

  // Output stage: the accepted write sits here for exactly one cycle.
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  // Per-requester views of the flattened address/data buses.
  logic [ADDR_W-1:0] w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0] w_data_arr [NUM_REQ];

  logic              w_found;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [PTR_W-1:0]  w_scan;
  logic              w_hs;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_gnt_nz;

  // Split the flat request buses into per-requester slices.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      w_data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and pick the first valid requester.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_scan    = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[w_scan]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan;
      end
      w_scan = wrap_inc(w_scan);
    end
  end

  // A grant is a handshake: the chosen requester is already valid.
  // Reset gates the grant combinationally so req_ready drops immediately.
  assign w_hs       = w_found && !flush && !reset;
  assign w_gnt_addr = w_addr_arr[w_gnt_idx];
  assign w_gnt_data = w_data_arr[w_gnt_idx];
  assign w_gnt_nz   = |w_gnt_addr;

  // One-hot ready on the granted index only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_hs && (w_gnt_idx == PTR_W'(i));
    end
  end

  // Advance the pointer past the winner so every requester gets a turn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= wrap_inc(w_gnt_idx);
    end
  end

  // Register the accepted write; x0 completes the handshake but never enables the write.
  // Address/data hold their last value when idle so the register-file inputs stay quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_hs) begin
      r_wr_en   <= w_gnt_nz;
      r_wr_addr <= w_gnt_addr;
      r_wr_data <= w_gnt_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  // The write on rf_write_* is exactly the one not yet visible in the register file,
  // so the bypass hint is a direct view of the output stage.
  assign rf_write_enable = r_wr_en;
  assign rf_write_addr   = r_wr_addr;
  assign rf_write_data   = r_wr_data;
  assign pend_valid      = r_wr_en;
  assign pend_addr       = r_wr_addr;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then randomized traffic against a reference model.
// Model tracks pointer, expected output stage and architectural register-file contents.
// Inputs change at posedge+1; DUT outputs are sampled at the falling edge.
module tb_regfile_wb_arbiter;
  localparam int NR = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              rf_write_enable;
  logic [AW-1:0]     rf_write_addr;
  logic [DW-1:0]     rf_write_data;
  logic              pend_valid;
  logic [AW-1:0]     pend_addr;

  regfile_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .reset           (rst),
    .flush           (flush),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .pend_valid      (pend_valid),
    .pend_addr       (pend_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int             m_ptr;
  logic           m_en;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_data;
  logic [DW-1:0]  m_rf  [32];
  logic [DW-1:0]  tb_rf [32];
  int             last_g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model grant: first valid index walking from the pointer, none under reset or flush.
  function automatic int model_grant();
    if (rst || flush) return -1;
    for (int k = 0; k < NR; k++) begin
      if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]       = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic assert_reset();
    rst    = 1'b1;
    m_ptr  = 0;
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock: check DUT against model at negedge, then advance the model at posedge.
  task automatic tick();
    int g;
    logic [63:0] e;
    @(negedge clk);
    g = model_grant();
    e = '0;
    if (g >= 0) e[g] = 1'b1;
    chk("ready",     {62'd0, req_ready}, e);
    chk("wr_en",     {63'd0, rf_write_enable}, {63'd0, m_en});
    chk("wr_addr",   {59'd0, rf_write_addr}, {59'd0, m_addr});
    chk("wr_data",   {32'd0, rf_write_data}, {32'd0, m_data});
    chk("pend_vld",  {63'd0, pend_valid}, {63'd0, m_en});
    chk("pend_addr", {59'd0, pend_addr}, {59'd0, m_addr});
    if (rf_write_enable) tb_rf[rf_write_addr] = rf_write_data;
    @(posedge clk);
    if (m_en) m_rf[m_addr] = m_data;
    if (g >= 0) begin
      m_ptr  = (g + 1) % NR;
      m_addr = req_addr[g*AW +: AW];
      m_data = req_data[g*DW +: DW];
      m_en   = (m_addr != 0);
    end else begin
      m_en = 1'b0;
    end
    last_g = g;
    #1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_rf[r]  = '0;
      tb_rf[r] = '0;
    end
    rst = 1'b0; flush = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; last_g = -1;

    // Reset state
    #2;
    assert_reset();
    #1;
    chk("rst_en",    {63'd0, rf_write_enable}, 64'd0);
    chk("rst_addr",  {59'd0, rf_write_addr}, 64'd0);
    chk("rst_data",  {32'd0, rf_write_data}, 64'd0);
    chk("rst_pend",  {63'd0, pend_valid}, 64'd0);
    chk("rst_ready", {62'd0, req_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    repeat (3) tick();

    // Single write from req0
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("t2_ready", {62'd0, req_ready}, 64'd1);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    chk("t2_en",    {63'd0, rf_write_enable}, 64'd1);
    chk("t2_addr",  {59'd0, rf_write_addr}, 64'd5);
    chk("t2_data",  {32'd0, rf_write_data}, 64'hDEADBEEF);
    chk("t2_pend",  {63'd0, pend_valid}, 64'd1);
    chk("t2_paddr", {59'd0, pend_addr}, 64'd5);
    tick();
    chk("t2_en_off", {63'd0, rf_write_enable}, 64'd0);

    // Write to x0 from req1: handshakes, never enabled
    set_req(1, 1'b1, 5'd0, 32'h55);
    #1 chk("t4_ready", {62'd0, req_ready}, 64'd2);
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0);
    chk("t4_en",   {63'd0, rf_write_enable}, 64'd0);
    chk("t4_pend", {63'd0, pend_valid}, 64'd0);

    // Both valid for 4 cycles: alternating grants starting at req0
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      #1 chk("t3_ready", {62'd0, req_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      chk("t3_addr", {59'd0, rf_write_addr}, (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0);

    // Flush: no grants, latched write still completes, pointer held
    set_req(0, 1'b1, 5'd3, 32'h33);
    tick();
    set_req(0, 1'b1, 5'd4, 32'h44);
    set_req(1, 1'b1, 5'd6, 32'h66);
    flush = 1'b1;
    #1;
    chk("t5_ready0", {62'd0, req_ready}, 64'd0);
    chk("t5_en",     {63'd0, rf_write_enable}, 64'd1);
    chk("t5_addr",   {59'd0, rf_write_addr}, 64'd3);
    tick();
    chk("t5_ready1", {62'd0, req_ready}, 64'd0);
    tick();
    flush = 1'b0;
    #1 chk("t5_after", {62'd0, req_ready}, 64'd2);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0);
    tick();

    // Asynchronous reset while a write is pending
    set_req(0, 1'b1, 5'd7, 32'h77);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b1, 5'd8, 32'h88);
    #1 chk("t6_pre_en", {63'd0, rf_write_enable}, 64'd1);
    assert_reset();
    #1;
    chk("t6_en",    {63'd0, rf_write_enable}, 64'd0);
    chk("t6_pend",  {63'd0, pend_valid}, 64'd0);
    chk("t6_ready", {62'd0, req_ready}, 64'd0);
    tick();
    set_req(0, 1'b1, 5'd9, 32'h99);
    set_req(1, 1'b1, 5'd10, 32'hAA);
    rst = 1'b0;
    #1 chk("t6_first", {62'd0, req_ready}, 64'd1);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0);
    tick();

    // Randomized traffic; requesters hold until handshake, small address range forces collisions
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && ($urandom % 3 == 0))
          set_req(i, 1'b1, AW'($urandom % 8), $urandom);
      end
      flush = ($urandom % 10 == 0);
      tick();
      if (last_g >= 0) set_req(last_g, 1'b0, 5'd0, 32'd0);
    end
    flush = 1'b0;
    req_valid = '0;
    repeat (3) tick();

    // Architectural register-file contents: last grant wins, x0 untouched
    for (int r = 0; r < 32; r++) begin
      chk($sformatf("rf[%0d]", r), {32'd0, tb_rf[r]}, {32'd0, m_rf[r]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
